// File: rtl/fir_pkg.sv
// Shared widths, saturation limits and the shift/saturate helper for the FIR output conditioner.
// Pure declarations: no latency, no flow control.
// Backpressure: not applicable.
package fir_pkg;

  localparam int DEF_IN_W    = 32;
  localparam int DEF_OUT_W   = 16;
  localparam int DEF_DEC_W   = 8;
  localparam int DEF_FIFO_AW = 4;
  localparam int SH_W        = 5;
  localparam int SAT_CNT_W   = 16;

  localparam logic [DEF_OUT_W-1:0] OUT_MAX = 16'h7FFF;
  localparam logic [DEF_OUT_W-1:0] OUT_MIN = 16'h8000;

  typedef struct packed {
    logic                 sat;
    logic [DEF_OUT_W-1:0] dat;
  } sat_res_t;

  // Arithmetic shift of the already-rounded sum, then clamp. The value fits in OUT_W
  // exactly when every bit from the output sign bit upward equals the top bit.
  function automatic sat_res_t sat_round(input logic signed [DEF_IN_W:0] s,
                                         input logic [SH_W-1:0] sh);
    logic signed [DEF_IN_W:0] t;
    sat_res_t r;
    t     = s >>> sh;
    r.sat = (t[DEF_IN_W:DEF_OUT_W-1] != {(DEF_IN_W-DEF_OUT_W+2){t[DEF_IN_W]}});
    r.dat = r.sat ? (t[DEF_IN_W] ? OUT_MIN : OUT_MAX) : t[DEF_OUT_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/fir_sfifo.sv
// Synchronous first-word-fall-through FIFO, depth 2**AW, with occupancy output.
// Latency: a write is visible at rd_dat the cycle after it is accepted.
// Backpressure: writes when full are ignored unless a read happens in the same cycle.
module fir_sfifo #(
  parameter int W  = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_dat,
  input  logic          rd_en,
  output logic [W-1:0]  rd_dat,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level
);

  logic [W-1:0] mem [0:(1<<AW)-1];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         do_rd;
  logic         do_wr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign level = wptr - rptr;
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);
  // Empty reads return 0 so the output is clean out of reset without clearing the array.
  assign rd_dat = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr[AW-1:0]] <= wr_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_wr) wptr <= wptr + (AW+1)'(1);
      if (do_rd) rptr <= rptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/fir_out_conditioner.sv
// Rounds, shifts, saturates and decimates FIR samples to 16 bits, then buffers them for a stream consumer.
// Latency: 3 clk from din to m_tvalid on an empty FIFO.
// Backpressure: none upstream; a sample reaching a full FIFO without a same-cycle read is dropped and flags ovf.
module fir_out_conditioner
  import fir_pkg::*;
#(
  parameter int IN_W    = DEF_IN_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int DEC_W   = DEF_DEC_W,
  parameter int FIFO_AW = DEF_FIFO_AW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_W-1:0]      din,
  input  logic                 din_vld,
  input  logic                 enable,
  input  logic [SH_W-1:0]      shift,
  input  logic [DEC_W-1:0]     decim,
  input  logic                 clr,
  output logic [OUT_W-1:0]     m_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic [FIFO_AW:0]     level,
  output logic                 ovf,
  output logic [SAT_CNT_W-1:0] sat_cnt
);

  logic [DEC_W-1:0]   decim_q;
  logic [DEC_W-1:0]   cnt;
  logic [DEC_W-1:0]   cnt_last;
  logic               keep;
  logic [IN_W:0]      rnd;
  logic signed [IN_W:0] s1;
  logic [SH_W-1:0]    s1_sh;
  logic               s1_vld;
  sat_res_t           res;
  logic [OUT_W-1:0]   s2_dat;
  logic               s2_vld;
  logic               sat_ev;
  logic               ovf_ev;
  logic               fifo_empty;
  logic               fifo_full;

  assign cnt_last = (decim == '0) ? '0 : decim - DEC_W'(1);
  assign keep     = din_vld & enable & (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      decim_q <= '0;
      cnt     <= '0;
    end else begin
      decim_q <= decim;
      if (!enable || decim != decim_q) cnt <= '0;
      else if (din_vld)                cnt <= (cnt >= cnt_last) ? '0 : cnt + DEC_W'(1);
    end
  end

  // Half-LSB rounding constant; the extra sum bit keeps din + rnd from wrapping.
  assign rnd = (shift != '0) ? ((IN_W+1)'(1) << (shift - SH_W'(1))) : '0;
  assign res = sat_round(s1, s1_sh);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= '0;
      s1_sh  <= '0;
      s1_vld <= 1'b0;
      s2_dat <= '0;
      s2_vld <= 1'b0;
    end else begin
      s1     <= {din[IN_W-1], din} + rnd;
      s1_sh  <= shift;
      s1_vld <= keep;
      s2_dat <= res.dat;
      s2_vld <= s1_vld;
    end
  end

  assign sat_ev = s1_vld & res.sat;
  assign ovf_ev = s2_vld & fifo_full & ~m_tready;

  // A same-cycle event survives clr: the new event is recorded on top of the cleared state.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf     <= 1'b0;
      sat_cnt <= '0;
    end else begin
      if (ovf_ev)   ovf <= 1'b1;
      else if (clr) ovf <= 1'b0;
      if (sat_ev) begin
        if (clr)                    sat_cnt <= SAT_CNT_W'(1);
        else if (sat_cnt != '1)     sat_cnt <= sat_cnt + SAT_CNT_W'(1);
      end else if (clr) begin
        sat_cnt <= '0;
      end
    end
  end

  fir_sfifo #(
    .W  (OUT_W),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (s2_vld),
    .wr_dat (s2_dat),
    .rd_en  (m_tready),
    .rd_dat (m_tdata),
    .empty  (fifo_empty),
    .full   (fifo_full),
    .level  (level)
  );

  assign m_tvalid = ~fifo_empty;

endmodule

// File: tb/tb_fir_out_conditioner.sv
// Directed bench for fir_out_conditioner: vector table for rounding/saturation plus
// hand sequences for latency, decimation, enable, overflow, clr and reset.
module tb_fir_out_conditioner;

  logic        clk;
  logic        rst;
  logic [31:0] din;
  logic        din_vld;
  logic        enable;
  logic [4:0]  shift;
  logic [7:0]  decim;
  logic        clr;
  logic [15:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic [4:0]  level;
  logic        ovf;
  logic [15:0] sat_cnt;

  int n_vec = 0;
  int n_err = 0;

  fir_out_conditioner dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .din_vld  (din_vld),
    .enable   (enable),
    .shift    (shift),
    .decim    (decim),
    .clr      (clr),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .level    (level),
    .ovf      (ovf),
    .sat_cnt  (sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] din;
    logic [4:0]  sh;
    logic [15:0] dat;
    logic        sat;
  } vec_t;

  vec_t vecs [14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [31:0] d);
    din     = d;
    din_vld = 1'b1;
    step();
    din_vld = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int exp_sat;
    logic [15:0] exp_q [$];

    vecs[0]  = '{32'd1000,     5'd0,  16'd1000, 1'b0};
    vecs[1]  = '{32'hFFFFFC18, 5'd0,  16'hFC18, 1'b0};
    vecs[2]  = '{32'd5,        5'd0,  16'd5,    1'b0};
    vecs[3]  = '{32'd24,       5'd4,  16'd2,    1'b0};
    vecs[4]  = '{32'hFFFFFFE8, 5'd4,  16'hFFFF, 1'b0};
    vecs[5]  = '{32'd23,       5'd4,  16'd1,    1'b0};
    vecs[6]  = '{32'hFFFFFFE7, 5'd4,  16'hFFFE, 1'b0};
    vecs[7]  = '{32'd40000,    5'd0,  16'h7FFF, 1'b1};
    vecs[8]  = '{32'hFFFF63C0, 5'd0,  16'h8000, 1'b1};
    vecs[9]  = '{32'h007FFF00, 5'd8,  16'h7FFF, 1'b0};
    vecs[10] = '{32'h80000000, 5'd31, 16'hFFFF, 1'b0};
    vecs[11] = '{32'hFFFFFFFD, 5'd1,  16'hFFFF, 1'b0};
    vecs[12] = '{32'h0000FFFF, 5'd1,  16'h7FFF, 1'b1};
    vecs[13] = '{32'h7FFFFFFF, 5'd16, 16'h7FFF, 1'b1};

    rst = 1'b1; din = '0; din_vld = 1'b0; enable = 1'b1; shift = '0;
    decim = 8'd1; clr = 1'b0; m_tready = 1'b1;
    repeat (3) step();
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_tdata", 32'(m_tdata), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_satcnt", 32'(sat_cnt), 32'd0);
    rst = 1'b0;
    repeat (2) step();

    // Back-to-back stream and exact 3-clk latency
    din = 32'd1000; din_vld = 1'b1; step();
    din = 32'hFFFFFC18; step();
    chk("lat_not_early", 32'(m_tvalid), 32'd0);
    din = 32'd5; step();
    din_vld = 1'b0;
    chk("stream0_vld", 32'(m_tvalid), 32'd1);
    chk("stream0_dat", 32'(m_tdata), 32'd1000);
    step();
    chk("stream1_dat", 32'(m_tdata), 32'h0000FC18);
    chk("stream1_lvl", 32'(level), 32'd1);
    step();
    chk("stream2_dat", 32'(m_tdata), 32'd5);
    step();
    chk("stream_drained", 32'(m_tvalid), 32'd0);

    // Each in-flight sample keeps the shift it entered with
    shift = 5'd4; din = 32'd24; din_vld = 1'b1; step();
    shift = 5'd0; step();
    din_vld = 1'b0; step();
    chk("inflight_sh4", 32'(m_tdata), 32'd2);
    step();
    chk("inflight_sh0", 32'(m_tdata), 32'd24);
    step();

    exp_sat = 0;
    for (int i = 0; i < 14; i++) begin
      shift = vecs[i].sh;
      send(vecs[i].din);
      step(); step();
      exp_sat += int'(vecs[i].sat);
      chk($sformatf("vec%0d_vld", i), 32'(m_tvalid), 32'd1);
      chk($sformatf("vec%0d_dat", i), 32'(m_tdata), 32'(vecs[i].dat));
      chk($sformatf("vec%0d_satcnt", i), 32'(sat_cnt), 32'(exp_sat));
      step();
      chk($sformatf("vec%0d_empty", i), 32'(level), 32'd0);
    end
    shift = 5'd0;

    clr = 1'b1; step(); clr = 1'b0;
    chk("clr_satcnt", 32'(sat_cnt), 32'd0);

    // Saturation event coincident with clr is still counted
    send(32'd40000);
    clr = 1'b1; step(); clr = 1'b0;
    chk("clr_vs_sat", 32'(sat_cnt), 32'd1);
    step();
    chk("clr_vs_sat_dat", 32'(m_tdata), 32'h7FFF);
    step();

    // Decimate by 4
    decim = 8'd4; repeat (2) step();
    m_tready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      din = 32'(i); din_vld = 1'b1; step();
    end
    din_vld = 1'b0; repeat (3) step();
    chk("dec4_level", 32'(level), 32'd4);
    m_tready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("dec4_out%0d", k), 32'(m_tdata), 32'(4 * k));
      step();
    end
    chk("dec4_drained", 32'(m_tvalid), 32'd0);

    // Decim change 4 -> 2 at sample 6 restarts the count
    m_tready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      decim = (i >= 6) ? 8'd2 : 8'd4;
      din = 32'(100 + i); din_vld = 1'b1; step();
    end
    din_vld = 1'b0; decim = 8'd1; repeat (3) step();
    exp_q = '{16'd100, 16'd104, 16'd107, 16'd109, 16'd111};
    chk("decchg_level", 32'(level), 32'd5);
    m_tready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("decchg_out%0d", k), 32'(m_tdata), 32'(exp_q[k]));
      step();
    end

    // Enable falling: sample already in the pipeline completes, later ones are ignored
    m_tready = 1'b0;
    din = 32'd50; din_vld = 1'b1; step();
    enable = 1'b0; din = 32'd51; step();
    din = 32'd52; step();
    enable = 1'b1; din_vld = 1'b0; repeat (3) step();
    chk("en_level", 32'(level), 32'd1);
    chk("en_dat", 32'(m_tdata), 32'd50);
    m_tready = 1'b1; step();
    chk("en_drained", 32'(m_tvalid), 32'd0);

    // Overflow: 20 samples into a stalled FIFO
    m_tready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      din = 32'(200 + i); din_vld = 1'b1; step();
    end
    din_vld = 1'b0; repeat (3) step();
    chk("full_level", 32'(level), 32'd16);
    chk("full_head", 32'(m_tdata), 32'd200);
    chk("full_ovf", 32'(ovf), 32'd1);
    clr = 1'b1; step(); clr = 1'b0;
    chk("ovf_clr", 32'(ovf), 32'd0);

    // Full FIFO with simultaneous read and write: no drop
    send(32'd300);
    step();
    m_tready = 1'b1; step(); m_tready = 1'b0;
    chk("fullrw_level", 32'(level), 32'd16);
    chk("fullrw_ovf", 32'(ovf), 32'd0);
    chk("fullrw_head", 32'(m_tdata), 32'd201);

    // Saturating sample dropped on full FIFO
    send(32'd40000);
    step();
    chk("drop_satcnt", 32'(sat_cnt), 32'd1);
    step();
    chk("drop_ovf", 32'(ovf), 32'd1);
    chk("drop_level", 32'(level), 32'd16);

    m_tready = 1'b1; repeat (7) step(); m_tready = 1'b0;
    chk("pre_rst_level", 32'(level), 32'd9);
    chk("pre_rst_head", 32'(m_tdata), 32'd208);

    // Reset mid-stream
    rst = 1'b1; din = 32'd7; din_vld = 1'b1; step();
    chk("midrst_level", 32'(level), 32'd0);
    chk("midrst_tvalid", 32'(m_tvalid), 32'd0);
    chk("midrst_tdata", 32'(m_tdata), 32'd0);
    chk("midrst_ovf", 32'(ovf), 32'd0);
    chk("midrst_satcnt", 32'(sat_cnt), 32'd0);
    step();
    chk("midrst_hold", 32'(m_tvalid), 32'd0);
    rst = 1'b0; din_vld = 1'b0; repeat (4) step();
    chk("postrst_idle", 32'(m_tvalid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
